// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word reads to instruction memory and buffers
// returned words with their PCs in a small queue feeding decode over valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [CntW-1:0] pend_q, pend_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [31:0]     pc_q   [DEPTH];
  logic [31:0]     pc_d   [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];
  logic [DEPTH-1:0] dv_q, dv_d;

  logic req_fire, rsp_fill, pop, redir_aligned;

  assign redir_aligned  = (redirect_pc[1:0] == 2'b00);
  assign imem_req_valid = !rst && (state_q == StRun) && (occ_q < DepthC) && !redirect_valid
                          && (drop_q == '0);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses owed to flushed requests are swallowed before any entry is filled.
  assign rsp_fill       = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);
  assign instr_valid    = dv_q[head_q];
  assign instr          = instr_valid ? data_q[head_q] : 32'h0;
  assign instr_pc       = instr_valid ? pc_q[head_q] : 32'h0;
  assign pop            = instr_valid && instr_ready;
  assign fetch_fault    = (state_q == StHalt);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    occ_d      = occ_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    data_d     = data_q;
    dv_d       = dv_q;

    if (redirect_valid) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      occ_d  = '0;
      pend_d = '0;
      dv_d   = '0;
      // Every entry still waiting for data becomes a response to discard.
      drop_d = drop_q + pend_q - CntW'(imem_rsp_valid);
      if (redir_aligned) begin
        state_d    = StRun;
        fetch_pc_d = redirect_pc;
      end else begin
        state_d = StHalt;
      end
    end else begin
      if (req_fire) begin
        pc_d[tail_q] = fetch_pc_q;
        dv_d[tail_q] = 1'b0;
        tail_d       = tail_q + PtrW'(1);
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
      if (rsp_fill) begin
        data_d[fill_q] = imem_rsp_data;
        dv_d[fill_q]   = 1'b1;
        fill_d         = fill_q + PtrW'(1);
      end
      if (pop) begin
        dv_d[head_q] = 1'b0;
        head_d       = head_q + PtrW'(1);
      end
      occ_d  = occ_q + CntW'(req_fire) - CntW'(pop);
      pend_d = pend_q + CntW'(req_fire) - CntW'(rsp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      dv_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      dv_q       <= dv_d;
    end
  end

  // Payload storage needs no reset; it is only observed behind its valid bit.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) begin
      assert ((drop_q != '0) || (pend_q != '0));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, checked against a
// program-order PC/data model and a latency-queue memory model.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Depth   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  instr_fetch_unit #(
    .RESET_PC(ResetPc),
    .DEPTH   (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_fault   (fetch_fault)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          alloc = 0;
  int          ndeliv = 0;
  int          nfires = 0;
  logic        halted = 1'b0;
  logic [31:0] exp_pc = ResetPc;
  logic [31:0] exp_req = ResetPc;
  logic [31:0] last_fire_addr = 32'h0;
  logic        s_fire = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  logic        first_pending = 1'b0;
  logic [31:0] first_pc = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive memory response, check outputs, advance the models.
  task automatic step();
    logic rsp;
    logic pop;
    #1;
    rsp = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom;
    #1;
    chk("fault_state", 32'(fetch_fault), 32'(halted));
    if (halted) begin
      chk("halt_no_req", 32'(imem_req_valid), 32'h0);
      chk("halt_no_instr", 32'(instr_valid), 32'h0);
    end
    if (rst || redirect_valid) chk("redirect_rst_no_req", 32'(imem_req_valid), 32'h0);
    if (stall_prev) chk("addr_stable", imem_req_addr, stall_addr);
    s_fire = imem_req_valid && imem_req_ready;
    if (s_fire) begin
      chk("req_addr", imem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      alloc++;
      nfires++;
      last_fire_addr = imem_req_addr;
      chk("alloc_bound", 32'(alloc <= int'(Depth)), 32'h1);
    end
    pop = instr_valid && instr_ready && !redirect_valid && !rst;
    if (pop) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_data", instr, memf(exp_pc));
      if (first_pending) begin
        first_pc      = instr_pc;
        first_pending = 1'b0;
      end
      exp_pc = exp_pc + 32'd4;
      alloc--;
      ndeliv++;
    end
    if (rsp) void'(mq.pop_front());
    stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid && !rst;
    stall_addr = imem_req_addr;
    if (rst) begin
      halted  = 1'b0;
      exp_pc  = ResetPc;
      exp_req = ResetPc;
      alloc   = 0;
      mq.delete();
    end else if (redirect_valid) begin
      alloc = 0;
      if (redirect_pc[1:0] == 2'b00) begin
        halted        = 1'b0;
        exp_pc        = redirect_pc;
        exp_req       = redirect_pc;
        first_pending = 1'b1;
      end else begin
        halted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_deliv(input string tag, input int n, input int budget);
    int start;
    int k;
    start = ndeliv;
    k     = 0;
    while ((ndeliv - start) < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(ndeliv - start), 32'(n));
  endtask

  task automatic wait_fire(input string tag, input logic [31:0] target, input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(s_fire && last_fire_addr == target) && k < budget);
    chk(tag, last_fire_addr, target);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int k;
    int nf;
    logic [31:0] held;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, ResetPc);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    step();
    rst = 1'b0;

    // 1: latency 1, always ready
    lat = 1;
    wait_deliv("t1_deliver", 4, 20);
    chk("t1_next_pc", exp_pc, 32'h10);

    // 2: decode stalls for 5 cycles
    instr_ready = 1'b0;
    nf = nfires;
    repeat (5) step();
    chk("t2_fires_bounded", 32'((nfires - nf) <= int'(Depth)), 32'h1);
    #1;
    chk("t2_req_valid_low", 32'(imem_req_valid), 32'h0);
    instr_ready = 1'b1;
    wait_deliv("t2_release", 4, 30);

    // 3: redirect with two requests in flight
    lat = 3;
    k   = 0;
    while (mq.size() != 2 && k < 20) begin
      step();
      k++;
    end
    chk("t3_outstanding", 32'(mq.size()), 32'h2);
    redirect_to(32'h0000_0100);
    wait_deliv("t3_deliver", 3, 40);
    chk("t3_first_pc", first_pc, 32'h0000_0100);

    // 4: misaligned redirect halts fetch until an aligned one
    lat = 1;
    redirect_to(32'h0000_0102);
    repeat (6) step();
    chk("t4_fault", 32'(fetch_fault), 32'h1);
    chk("t4_no_req", 32'(imem_req_valid), 32'h0);
    redirect_to(32'h0000_0200);
    wait_deliv("t4_resume", 2, 20);
    chk("t4_first_pc", first_pc, 32'h0000_0200);
    chk("t4_fault_clear", 32'(fetch_fault), 32'h0);

    // 5: memory back-pressure
    imem_req_ready = 1'b0;
    k = 0;
    do begin
      step();
      k++;
      #1;
    end while (!imem_req_valid && k < 10);
    chk("t5_req_pending", 32'(imem_req_valid), 32'h1);
    held = imem_req_addr;
    repeat (3) step();
    chk("t5_addr_held", imem_req_addr, held);
    imem_req_ready = 1'b1;
    nf = nfires;
    step();
    chk("t5_single_alloc", 32'(nfires - nf), 32'h1);
    chk("t5_alloc_addr", last_fire_addr, held);

    // 6: PC wrap, then reset mid-stream
    redirect_to(32'hFFFF_FFF8);
    wait_fire("t6_top", 32'hFFFF_FFFC, 20);
    k = 0;
    do begin
      step();
      k++;
    end while (!s_fire && k < 20);
    chk("t6_wrap", last_fire_addr, 32'h0000_0000);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!s_fire && k < 20);
    chk("t6_reset_pc", last_fire_addr, ResetPc);
    chk("t6_reset_fire", 32'(s_fire), 32'h1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      lat            = int'($urandom_range(1, 3));
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_to(32'h0000_0400);
    wait_deliv("rand_drain", 3, 40);
    chk("rand_first_pc", first_pc, 32'h0000_0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
